// File: rtl/mmio_console_pkg.sv
// Shared constants for the MMIO console: access sizes, register offsets,
// STATUS bit layout and a small saturation helper.
package mmio_console_pkg;

  localparam logic [1:0] sz_byte = 2'd0;
  localparam logic [1:0] sz_half = 2'd1;
  localparam logic [1:0] sz_word = 2'd2;

  typedef enum logic [1:0] {
    con_txdata = 2'd0,
    con_status = 2'd1,
    con_exit   = 2'd2,
    con_cycles = 2'd3
  } con_reg_e;

  localparam int st_full      = 0;
  localparam int st_empty     = 1;
  localparam int st_overflow  = 2;
  localparam int st_done      = 3;
  localparam int st_count_lsb = 8;

  // Field order mirrors the st_* bit positions above.
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        done;
    logic        overflow;
    logic        empty;
    logic        full;
  } status_t;

  function automatic logic [7:0] sat_count8(input logic [31:0] v);
    if (v > 32'd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/mmio_console_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; the caller is responsible for never
// pushing into a full FIFO unless it pops in the same cycle.
module byte_fifo #(
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [aw:0] r_wptr;
  logic [aw:0] r_rptr;
  logic [7:0]  r_mem [depth];
  logic        w_do_pop;

  assign w_do_pop = pop && !empty;
  assign empty    = (r_wptr == r_rptr);
  assign full     = (r_wptr[aw] != r_rptr[aw]) && (r_wptr[aw-1:0] == r_rptr[aw-1:0]);
  assign count    = r_wptr - r_rptr;
  assign dout     = r_mem[r_rptr[aw-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= {(aw + 1){1'b0}};
      r_rptr <= {(aw + 1){1'b0}};
    end else begin
      if (push) begin
        r_wptr <= r_wptr + ptr_one;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + ptr_one;
      end
    end
  end

  // Storage is cleared on reset so the head byte reads as zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (push) begin
      r_mem[r_wptr[aw-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console/exit responder on the processor data port: TX byte
// FIFO, sticky EXIT register, free-running cycle counter and status.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] base  = 32'hFFFF0000,
  parameter int          depth = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] addr,
  input  logic        rd_wr,
  input  logic [1:0]  access_size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] exit_code
);

  localparam int cw = $clog2(depth) + 1;

  logic          w_hit;
  logic          w_rd;
  logic          w_wr;
  con_reg_e      w_off;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_drop;
  logic [cw-1:0] w_count;
  logic [7:0]    w_fifo_dout;
  status_t       w_status;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  logic          r_done;
  logic          r_overflow;
  logic [31:0]   r_exit_code;
  logic [31:0]   r_cycles;
  logic [31:0]   r_data_out;

  assign w_hit         = enable && (addr[31:4] == base[31:4]);
  assign w_rd          = w_hit && rd_wr;
  assign w_wr          = w_hit && !rd_wr;
  assign w_off         = con_reg_e'(addr[3:2]);
  // TXDATA takes the low byte regardless of size; byte lanes are irrelevant here.
  assign w_unused_bits = ^{access_size, addr[1:0]};

  assign w_pop      = !w_empty && tx_ready;
  assign w_push_req = w_wr && (w_off == con_txdata);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  byte_fifo #(
    .depth(depth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .din  (data_in[7:0]),
    .pop  (w_pop),
    .dout (w_fifo_dout),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  // STATUS word assembly.
  always_comb begin
    w_status          = status_t'(32'h0000_0000);
    w_status.full     = w_full;
    w_status.empty    = w_empty;
    w_status.overflow = r_overflow;
    w_status.done     = r_done;
    w_status.count    = sat_count8(32'(w_count));
  end

  // Read mux over the four registers.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_off)
      con_txdata: w_rdata = 32'h0000_0000;
      con_status: w_rdata = w_status;
      con_exit:   w_rdata = r_exit_code;
      con_cycles: w_rdata = r_cycles;
      default:    w_rdata = 32'h0000_0000;
    endcase
  end

  // Read data register; zero on non-hit cycles so it can be OR-ed with memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= 32'h0000_0000;
    end else if (w_rd) begin
      r_data_out <= w_rdata;
    end else begin
      r_data_out <= 32'h0000_0000;
    end
  end

  // EXIT register and sticky done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exit_code <= 32'h0000_0000;
      r_done      <= 1'b0;
    end else if (w_wr && (w_off == con_exit)) begin
      r_exit_code <= data_in;
      r_done      <= 1'b1;
    end
  end

  // Sticky overflow for bytes dropped on a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= 32'h0000_0000;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign data_out  = r_data_out;
  assign tx_data   = w_fifo_dout;
  assign tx_valid  = !w_empty;
  assign done      = r_done;
  assign exit_code = r_exit_code;

endmodule
